// File: rtl/apb4_pkg.sv
// Shared types for the two-requester APB4 master: FSM state encoding,
// the latched command record and the slave count.
package apb4_pkg;

  localparam int SLV_COUNT = 2;

  // Field widths of the latched command; the master's DATA_WIDTH and
  // ADDR_WIDTH parameters are expected to match these.
  localparam int CMD_AW = 32;
  localparam int CMD_DW = 32;
  localparam int CMD_SW = CMD_DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb4_state_t;

  typedef struct packed {
    logic              write;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
    logic [CMD_SW-1:0] strb;
  } apb4_cmd_t;

endpackage

// File: rtl/apb4_rr_arbiter.sv
// Two-way round-robin grant. last_grant remembers which requester was served
// most recently; on contention the other one wins. last_grant resets to 1 so
// requester 0 wins the first contention. gnt_id is combinational and only
// meaningful while any_req is high.
module apb4_rr_arbiter (
  input  logic PCLK,
  input  logic PRESET,
  input  logic req0,
  input  logic req1,
  input  logic upd_en,
  input  logic upd_id,
  output logic gnt_id,
  output logic any_req
);

  logic last_grant;

  // Record the requester whose transfer just completed.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_grant <= 1'b1;
    end else if (upd_en) begin
      last_grant <= upd_id;
    end
  end

  // Pick the winner: the lone requester, or the one not served last.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = req1 & ~req0;
    end
  end

endmodule

// File: rtl/apb4_arb_master.sv
// Two-requester APB4 master. Arbitrates between two command sources, latches
// the winner's command, runs IDLE->SETUP->ACCESS on PSEL1/PSEL2 selected by
// address bit SEL_BIT, and returns rdata/err with a one-cycle done pulse.
// Optional feature macro: APB4_ARB_TIMEOUT_EN bounds the ACCESS wait to
// TIMEOUT_CYCLES cycles and then completes with err=1, rdata=0.
//
// Requester handshake: reqN_valid is held with a stable command until
// reqN_done pulses for one cycle; rdata/err are valid only while done is high
// and read zero otherwise. The command is captured at grant, so later changes
// on the request lines or a dropped valid do not affect the transfer.
module apb4_arb_master
  import apb4_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_BIT        = 6,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [STRB_WIDTH-1:0] req0_strb,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [STRB_WIDTH-1:0] req1_strb,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  input  logic                  PREADY1,
  input  logic                  PREADY2,
  input  logic [DATA_WIDTH-1:0] PRDATA1,
  input  logic [DATA_WIDTH-1:0] PRDATA2,
  input  logic                  PSLVERR1,
  input  logic                  PSLVERR2,
  output logic [1:0]            dbg_state
);

  apb4_state_t state_q, state_n;
  apb4_cmd_t   cmd_q, cmd_n, win_cmd;

  logic                  gid_q, gid_n;       // granted requester
  logic                  dsel_q, dsel_n;     // 0 = slave 1, 1 = slave 2
  logic                  hold_q, hold_n;     // decode-error response pending
  logic [SLV_COUNT-1:0]  psel_q, psel_n;
  logic                  penable_q, penable_n;
  logic [1:0]            done_q, done_n;
  logic [1:0]            err_q, err_n;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_n, rdata1_q, rdata1_n;

  logic                  gnt_id, any_req, arb_upd;
  logic                  win_oor;
  logic                  sel_ready, sel_slverr;
  logic [DATA_WIDTH-1:0] sel_prdata;
  logic                  rsp_fire, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  tmo_hit;

  apb4_rr_arbiter u_arb (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .upd_en  (arb_upd),
    .upd_id  (gid_q),
    .gnt_id  (gnt_id),
    .any_req (any_req)
  );

  // Winner's command and its address-range check.
  always_comb begin
    if (gnt_id) begin
      win_cmd.write = req1_write;
      win_cmd.addr  = req1_addr;
      win_cmd.wdata = req1_wdata;
      win_cmd.strb  = req1_strb;
    end else begin
      win_cmd.write = req0_write;
      win_cmd.addr  = req0_addr;
      win_cmd.wdata = req0_wdata;
      win_cmd.strb  = req0_strb;
    end
    win_oor = |win_cmd.addr[ADDR_WIDTH-1:SEL_BIT+1];
  end

  // Response signals of the currently selected slave.
  always_comb begin
    sel_ready  = dsel_q ? PREADY2  : PREADY1;
    sel_prdata = dsel_q ? PRDATA2  : PRDATA1;
    sel_slverr = dsel_q ? PSLVERR2 : PSLVERR1;
  end

`ifdef APB4_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Count ACCESS cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge PCLK) begin
    if (PRESET || state_q != ACCESS) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state_q == ACCESS) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n   = state_q;
    cmd_n     = cmd_q;
    gid_n     = gid_q;
    dsel_n    = dsel_q;
    hold_n    = hold_q;
    psel_n    = '0;
    penable_n = 1'b0;
    done_n    = '0;
    err_n     = '0;
    rdata0_n  = '0;
    rdata1_n  = '0;
    rsp_fire  = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    arb_upd   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gid_n = gnt_id;
          if (win_oor) begin
            // No APB cycle; the response is issued from RESP one cycle later.
            hold_n  = 1'b1;
            state_n = RESP;
          end else begin
            cmd_n  = win_cmd;
            dsel_n = win_cmd.addr[SEL_BIT];
            psel_n[win_cmd.addr[SEL_BIT]] = 1'b1;
            state_n = SETUP;
          end
        end
      end
      SETUP: begin
        psel_n[dsel_q] = 1'b1;
        penable_n      = 1'b1;
        state_n        = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          rsp_fire  = 1'b1;
          rsp_rdata = cmd_q.write ? '0 : sel_prdata;
          rsp_err   = sel_slverr;
          state_n   = RESP;
        end else if (tmo_hit) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_n  = RESP;
        end else begin
          psel_n[dsel_q] = 1'b1;
          penable_n      = 1'b1;
        end
      end
      RESP: begin
        if (hold_q) begin
          hold_n   = 1'b0;
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end else begin
          arb_upd = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rsp_fire) begin
      done_n[gid_q] = 1'b1;
      err_n[gid_q]  = rsp_err;
      if (gid_q) begin
        rdata1_n = rsp_rdata;
      end else begin
        rdata0_n = rsp_rdata;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cmd_q     <= '0;
      gid_q     <= 1'b0;
      dsel_q    <= 1'b0;
      hold_q    <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      done_q    <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      cmd_q     <= cmd_n;
      gid_q     <= gid_n;
      dsel_q    <= dsel_n;
      hold_q    <= hold_n;
      psel_q    <= psel_n;
      penable_q <= penable_n;
      done_q    <= done_n;
      err_q     <= err_n;
      rdata0_q  <= rdata0_n;
      rdata1_q  <= rdata1_n;
    end
  end

  assign PADDR      = cmd_q.addr;
  assign PWRITE     = cmd_q.write;
  assign PWDATA     = cmd_q.wdata;
  assign PSTRB      = cmd_q.strb;
  assign PSEL1      = psel_q[0];
  assign PSEL2      = psel_q[1];
  assign PENABLE    = penable_q;
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_apb4_arb_master.sv
// Directed bench for apb4_arb_master with two one-wait-state memory slaves.
module tb_apb4_arb_master;

  logic        PCLK, PRESET;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [3:0]  req0_strb, req1_strb;
  logic        req0_done, req0_err, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic        PWRITE, PSEL1, PSEL2, PENABLE;
  logic [3:0]  PSTRB;
  logic        PREADY1, PREADY2, PSLVERR1, PSLVERR2;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave models: one wait state, optional forced error / stall on slave 1.
  logic [31:0] mem1 [16];
  logic [31:0] mem2 [16];
  logic        wait1, wait2, slverr1, stall1;

  apb4_arb_master dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
    .PREADY1(PREADY1), .PREADY2(PREADY2), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PSLVERR1(PSLVERR1), .PSLVERR2(PSLVERR2), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign PREADY1  = PSEL1 && PENABLE && wait1 && !stall1;
  assign PREADY2  = PSEL2 && PENABLE && wait2;
  assign PRDATA1  = mem1[PADDR[5:2]];
  assign PRDATA2  = mem2[PADDR[5:2]];
  assign PSLVERR1 = slverr1 && PREADY1;
  assign PSLVERR2 = 1'b0;

  always @(posedge PCLK) begin
    if (PRESET) begin
      wait1 <= 1'b0;
      wait2 <= 1'b0;
    end else begin
      wait1 <= PSEL1 && PENABLE && !PREADY1;
      wait2 <= PSEL2 && PENABLE && !PREADY2;
      if (PSEL1 && PENABLE && PREADY1 && PWRITE)
        for (int b = 0; b < 4; b++)
          if (PSTRB[b]) mem1[PADDR[5:2]][b*8 +: 8] <= PWDATA[b*8 +: 8];
      if (PSEL2 && PENABLE && PREADY2 && PWRITE)
        for (int b = 0; b < 4; b++)
          if (PSTRB[b]) mem2[PADDR[5:2]][b*8 +: 8] <= PWDATA[b*8 +: 8];
    end
  end

  // Driver: one request on requester n, returns response and bus activity.
  task automatic drive_req(input int n, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int n_setup, output int n_access,
                           output int n_sel1, output int n_sel2, output int n_other);
    logic got;
    got = 1'b0; lat = 0; rd = '0; er = 1'b0;
    n_setup = 0; n_access = 0; n_sel1 = 0; n_sel2 = 0; n_other = 0;
    if (n == 0) begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_strb = strb;
    end else begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_strb = strb;
    end
    while (!got && lat < 64) begin
      @(posedge PCLK); #1;
      lat++;
      if ((PSEL1 || PSEL2) && !PENABLE) n_setup++;
      if (PENABLE) n_access++;
      if (PSEL1) n_sel1++;
      if (PSEL2) n_sel2++;
      if (n == 0) begin
        if (req1_done || req1_err || req1_rdata != 0) n_other++;
        if (req0_done) begin got = 1'b1; rd = req0_rdata; er = req0_err; end
      end else begin
        if (req0_done || req0_err || req0_rdata != 0) n_other++;
        if (req1_done) begin got = 1'b1; rd = req1_rdata; er = req1_err; end
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!got) lat = -1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset;
    n_checks++; if (PSEL1 !== 1'b0) begin n_fail++; $display("FAIL reset_psel1: got %b want 0", PSEL1); end
    n_checks++; if (PSEL2 !== 1'b0) begin n_fail++; $display("FAIL reset_psel2: got %b want 0", PSEL2); end
    n_checks++; if (PENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_penable: got %b want 0", PENABLE); end
    n_checks++; if ({PADDR, PWDATA, PSTRB, PWRITE} !== 69'd0) begin n_fail++; $display("FAIL reset_cmd: got %h/%h/%h/%b want 0", PADDR, PWDATA, PSTRB, PWRITE); end
    n_checks++; if ({req0_done, req1_done, req0_err, req1_err} !== 4'd0) begin n_fail++; $display("FAIL reset_done_err: got %b%b%b%b want 0000", req0_done, req1_done, req0_err, req1_err); end
    n_checks++; if ({req0_rdata, req1_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0", req0_rdata, req1_rdata); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL idle_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int lat, ns, na, s1, s2, oth;
    drive_req(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, er, lat, ns, na, s1, s2, oth);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL wr_latency: got %0d want 4", lat); end
    n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL wr_resp: got err %b rdata %h want 0/0", er, rd); end
    n_checks++; if (ns !== 1 || na !== 2) begin n_fail++; $display("FAIL wr_phases: got setup %0d access %0d want 1/2", ns, na); end
    n_checks++; if (s1 !== 3 || s2 !== 0 || oth !== 0) begin n_fail++; $display("FAIL wr_select: got sel1 %0d sel2 %0d other %0d want 3/0/0", s1, s2, oth); end
    drive_req(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat, ns, na, s1, s2, oth);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    n_checks++; if (lat !== 4 || er !== 1'b0) begin n_fail++; $display("FAIL rd_resp: got lat %0d err %b want 4/0", lat, er); end
  endtask

  task automatic test_strobe;
    logic [31:0] rd; logic er; int lat, ns, na, s1, s2, oth;
    drive_req(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, rd, er, lat, ns, na, s1, s2, oth);
    drive_req(0, 1'b1, 32'h08, 32'h00000000, 4'h2, rd, er, lat, ns, na, s1, s2, oth);
    drive_req(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat, ns, na, s1, s2, oth);
    n_checks++; if (rd !== 32'hFFFF00FF) begin n_fail++; $display("FAIL strobe_data: got %h want ffff00ff", rd); end
  endtask

  task automatic test_slave_select;
    logic [31:0] rd; logic er; int lat, ns, na, s1, s2, oth;
    drive_req(1, 1'b1, 32'h44, 32'h12345678, 4'hF, rd, er, lat, ns, na, s1, s2, oth);
    n_checks++; if (s1 !== 0 || s2 !== 3) begin n_fail++; $display("FAIL sel2_only: got sel1 %0d sel2 %0d want 0/3", s1, s2); end
    n_checks++; if (lat !== 4 || er !== 1'b0 || oth !== 0) begin n_fail++; $display("FAIL sel2_resp: got lat %0d err %b other %0d want 4/0/0", lat, er, oth); end
    drive_req(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat, ns, na, s1, s2, oth);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL slv1_kept: got %h want deadbeef", rd); end
    drive_req(1, 1'b0, 32'h44, 32'h0, 4'h0, rd, er, lat, ns, na, s1, s2, oth);
    n_checks++; if (rd !== 32'h12345678 || s2 !== 3) begin n_fail++; $display("FAIL slv2_read: got %h sel2 %0d want 12345678/3", rd, s2); end
  endtask

  task automatic test_slverr;
    logic [31:0] rd; logic er; int lat, ns, na, s1, s2, oth;
    slverr1 = 1'b1;
    drive_req(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat, ns, na, s1, s2, oth);
    slverr1 = 1'b0;
    n_checks++; if (er !== 1'b1 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL slverr: got err %b rdata %h want 1/deadbeef", er, rd); end
  endtask

  task automatic test_decode_error;
    logic [31:0] rd; logic er; int lat, ns, na, s1, s2, oth;
    drive_req(1, 1'b0, 32'h100, 32'h0, 4'h0, rd, er, lat, ns, na, s1, s2, oth);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL dec_latency: got %0d want 2", lat); end
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL dec_resp: got err %b rdata %h want 1/0", er, rd); end
    n_checks++; if (s1 !== 0 || s2 !== 0 || oth !== 0) begin n_fail++; $display("FAIL dec_no_psel: got sel1 %0d sel2 %0d other %0d want 0/0/0", s1, s2, oth); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat, ns, na, s1, s2, oth, cyc;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h10; req0_wdata = 32'hA5A5A5A5; req0_strb = 4'hF;
    cyc = 0;
    while (PENABLE !== 1'b1 && cyc < 10) begin @(posedge PCLK); #1; cyc++; end
    n_checks++; if (PENABLE !== 1'b1) begin n_fail++; $display("FAIL rst_reach_access: got penable %b want 1", PENABLE); end
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    n_checks++; if ({PSEL1, PSEL2, PENABLE, req0_done, req1_done} !== 5'd0) begin n_fail++; $display("FAIL rst_ctrl: got %b%b%b%b%b want 00000", PSEL1, PSEL2, PENABLE, req0_done, req1_done); end
    n_checks++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_cmd: got %h %h state %0d want 0 0 0", PADDR, PWDATA, dbg_state); end
    PRESET = 1'b0; req0_valid = 1'b0;
    @(posedge PCLK); #1;
    n_checks++; if (req0_done !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got %b want 0", req0_done); end
    drive_req(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ns, na, s1, s2, oth);
    n_checks++; if (lat !== 4 || rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL rst_recover: got lat %0d rdata %h err %b want 4/0/0", lat, rd, er); end
  endtask

  task automatic test_back_to_back;
    int order [4]; int nd, cyc, ns, na, s2, both;
    for (int i = 0; i < 4; i++) order[i] = -1;
    nd = 0; cyc = 0; ns = 0; na = 0; s2 = 0; both = 0;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h20; req0_wdata = 32'h11111111; req0_strb = 4'hF;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h24; req1_wdata = 32'h22222222; req1_strb = 4'hF;
    while (nd < 4 && cyc < 60) begin
      @(posedge PCLK); #1;
      cyc++;
      if ((PSEL1 || PSEL2) && !PENABLE) ns++;
      if (PENABLE) na++;
      if (PSEL2) s2++;
      if (req0_done && req1_done) both++;
      if (req0_done && nd < 4) begin order[nd] = 0; nd++; end
      if (req1_done && nd < 4) begin order[nd] = 1; nd++; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge PCLK); #1;
    n_checks++; if (nd !== 4 || cyc !== 19) begin n_fail++; $display("FAIL b2b_count: got %0d dones in %0d cycles want 4 in 19", nd, cyc); end
    n_checks++; if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1)
      begin n_fail++; $display("FAIL b2b_order: got %0d%0d%0d%0d want 0101", order[0], order[1], order[2], order[3]); end
    n_checks++; if (ns !== 4 || na !== 8 || s2 !== 0 || both !== 0) begin n_fail++; $display("FAIL b2b_phases: got setup %0d access %0d sel2 %0d both %0d want 4/8/0/0", ns, na, s2, both); end
  endtask

`ifdef APB4_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] rd; logic er; int lat, ns, na, s1, s2, oth;
    stall1 = 1'b1;
    drive_req(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat, ns, na, s1, s2, oth);
    stall1 = 1'b0;
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL tmo_resp: got err %b rdata %h want 1/0", er, rd); end
    n_checks++; if (lat !== 18 || na !== 16) begin n_fail++; $display("FAIL tmo_timing: got lat %0d access %0d want 18/16", lat, na); end
    n_checks++; if (PSEL1 !== 1'b0 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL tmo_release: got psel1 %b penable %b want 0/0", PSEL1, PENABLE); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin mem1[i] = '0; mem2[i] = '0; end
    slverr1 = 1'b0; stall1 = 1'b0;
    PRESET = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_strb = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; req1_strb = '0;
    repeat (3) @(posedge PCLK);
    #1;
    test_reset;
    test_write_read;
    test_strobe;
    test_slave_select;
    test_slverr;
    test_decode_error;
    test_reset_mid;
    test_back_to_back;
`ifdef APB4_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb4_arb_master.md
# apb4_arb_master

Two-requester APB4 master with round-robin arbitration. It sits between two internal command sources (for example a CPU bridge and a DMA engine) and the APB4 bus that serves two memory slaves of the APB4_MEM_SLV family. It latches one command per grant and sequences the IDLE→SETUP→ACCESS protocol. It decodes the address to PSEL1/PSEL2, waits for PREADY, and returns read data and error status to the granted requester.

## Interface
- DATA_WIDTH, 32, APB data width; STRB_WIDTH = DATA_WIDTH/8 is derived.
- ADDR_WIDTH, 32, APB address width.
- SEL_BIT, 6, address bit that selects the slave: 0 → slave 1, 1 → slave 2.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only when the timeout macro is defined.
- PCLK  in  1  the single clock.
- PRESET  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request from requester N (N = 0, 1); held until reqN_done.
- reqN_write  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  byte/word address passed through to PADDR.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_strb  in  STRB_WIDTH  write strobes.
- reqN_done  out  1  one-cycle completion pulse.
- reqN_rdata  out  DATA_WIDTH  read data, valid while reqN_done is high.
- reqN_err  out  1  error flag, valid while reqN_done is high.
- PADDR, PWRITE, PWDATA, PSTRB  out  APB command outputs, held stable from SETUP through completion.
- PSEL1, PSEL2, PENABLE  out  1  APB control outputs.
- PREADY1, PREADY2  in  1  slave ready inputs.
- PRDATA1, PRDATA2  in  DATA_WIDTH  slave read data inputs.
- PSLVERR1, PSLVERR2  in  1  slave error inputs.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any reqN_valid is high, arbitrate and latch the winner's command into internal registers, then go to SETUP. If the address is out of range, go to RESP with err=1 instead.
- Out-of-range address: any of reqN_addr[ADDR_WIDTH-1:SEL_BIT+1] is nonzero.
- Arbitration is round-robin on a last_grant flag:
  - Both requests valid: the requester that was not served last wins.
  - last_grant resets to 1, so requester 0 wins the first contention.
- SETUP: PSELx=1 for the decoded slave, PENABLE=0. Next state is ACCESS unconditionally.
- ACCESS: PSELx=1, PENABLE=1. Stay in ACCESS until the selected PREADYx is sampled high.
- At the PREADYx edge:
  - Capture the selected PRDATAx (reads only; writes return 0) and the selected PSLVERRx.
  - Drop PSEL and PENABLE.
  - Go to RESP.
- RESP: pulse reqN_done for the granted requester with the captured rdata/err, update last_grant, and return to IDLE.
- A requester may present its next request in the cycle after done.
- Only the granted requester's rdata is updated; the other requester's done, rdata and err stay 0.
- Dropping reqN_valid mid-transfer is ignored: the transfer completes and done still pulses.
- A command change while the request is in flight has no effect, because the command was latched at grant.

## Timing
- Reset values: PSEL1/2=0, PENABLE=0, PADDR/PWDATA/PSTRB/PWRITE=0, all reqN_done/rdata/err=0, FSM=IDLE, last_grant=1.
- All outputs are registered.
- Request sampled in IDLE at edge t:
  - SETUP visible t+1, ACCESS t+2.
  - The memory slave asserts PREADY at the earliest in cycle t+3.
  - done is visible at t+4 at the earliest.
- Minimum request-to-done latency is 4 cycles, plus wait states. Minimum throughput is one transfer per 5 cycles.
- Decode error: done+err is visible at t+2 and no APB cycle is issued.
- Reset asserted in any state: next edge returns to IDLE with all outputs at reset values. No done is emitted for the aborted transfer.

## Configuration
- APB4_ARB_TIMEOUT_EN defined:
  - An ACCESS-cycle counter runs from entry into ACCESS.
  - If PREADY is still low after TIMEOUT_CYCLES ACCESS cycles, drop PSEL/PENABLE, go to RESP, and return err=1, rdata=0.
- APB4_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

## Structure
- Shared package apb4_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS, RESP);
  - an apb4_cmd_t struct (write, addr, wdata, strb);
  - the localparam SLV_COUNT = 2.
- One natural sub-module, apb4_rr_arbiter: a 2-way round-robin grant with last_grant state and a grant-update enable.

## Test plan
- Single write then read: req0 writes addr 0x04, wdata 0xDEADBEEF, strb 0xF. Then req0 reads 0x04 → rdata=0xDEADBEEF, err=0, done at request+4.
- Byte strobe: write 0xFFFFFFFF, then write 0x00000000 with strb 0x2, then read → 0xFFFF00FF.
- Slave select: req1 writes addr 0x44 (SEL_BIT set) with 0x12345678 → only PSEL2 pulses. A read of 0x04 returns the earlier slave-1 data unchanged.
- Contention: req0 and req1 are both valid continuously for 4 transfers → grants alternate 0,1,0,1, each done pulses exactly once per transfer, and PSEL/PENABLE follow SETUP→ACCESS each time.
- Decode error and reset: a request to 0x100 → done+err at t+2 with no PSEL. PRESET asserted in ACCESS → next cycle all outputs 0, no done, and the next request proceeds normally.
- Timeout (with APB4_ARB_TIMEOUT_EN): PREADY tied low → done with err=1, rdata=0 after 16 ACCESS cycles, PSEL deasserted.
